// File: rtl/bmem_responder_if.sv
// Burst memory bus (bmem_*) between an initiator (master) and the memory responder (slave).
interface bmem_responder_if;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;
    logic        proto_err;

    modport master (
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, proto_err
    );

    modport slave (
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, proto_err
    );
endinterface

// File: rtl/bmem_responder.sv
// Synthesizable backing store for the bmem_* bus: 256-bit lines, 4-beat write bursts,
// pipelined reads returned as 4 x 64-bit beats after a fixed latency.
module bmem_responder #(
    parameter int unsigned MEM_LINES       = 256,
    parameter int unsigned READ_LATENCY    = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst,
    bmem_responder_if.slave  bus
);
    localparam int unsigned IDXW = $clog2(MEM_LINES);
    localparam int unsigned QW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [15:0]   LAT   = 16'(READ_LATENCY);
    localparam logic [QW-1:0] QLAST = QW'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {W_IDLE, W_BEAT1, W_BEAT2, W_BEAT3} wstate_e;

    logic [255:0]    mem_q [MEM_LINES];

    wstate_e         wstate_q, wstate_d;
    logic [IDXW-1:0] widx_q;
    logic [191:0]    wbuf_q;
    logic            proto_err_q, proto_err_d;
    logic            live_q;

    logic [31:0]     qaddr_q [MAX_OUTSTANDING];
    logic [255:0]    qline_q [MAX_OUTSTANDING];
    logic [15:0]     qts_q   [MAX_OUTSTANDING];
    logic [QW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     now_q;

    logic            rvalid_q, rvalid_d;
    logic [63:0]     rdata_q, rdata_d;
    logic [31:0]     raddr_q, raddr_d;
    logic [1:0]      beat_q, beat_d;
    logic [255:0]    line_q, line_d;

    logic            ready, wr_acc, rd_acc, commit, pop;
    logic [IDXW-1:0] req_idx;
    logic [15:0]     head_age;
    logic [1:0]      beat_nxt;
    logic [4:0]      unused_addr_bits;

    function automatic logic [QW-1:0] nxt_ptr(input logic [QW-1:0] p);
        return (p == QLAST) ? '0 : p + 1'b1;
    endfunction

    assign unused_addr_bits = bus.bmem_addr[4:0];
    assign req_idx  = bus.bmem_addr[5 +: IDXW];
    assign ready    = live_q && (wstate_q == W_IDLE) && (cnt_q < CW'(MAX_OUTSTANDING));
    assign wr_acc   = ready & bus.bmem_write;
    assign rd_acc   = ready & bus.bmem_read & ~bus.bmem_write;
    assign head_age = now_q - qts_q[rptr_q];
    assign pop      = (cnt_q != '0) && (head_age >= LAT) && (!rvalid_q || beat_q == 2'd3);
    assign beat_nxt = beat_q + 2'd1;

    // Write burst sequencing: next state, commit strobe and sticky protocol-error flag.
    always_comb begin
        wstate_d    = wstate_q;
        commit      = 1'b0;
        proto_err_d = proto_err_q;
        if (ready && bus.bmem_read && bus.bmem_write) proto_err_d = 1'b1;
        case (wstate_q)
            W_IDLE:  if (wr_acc) wstate_d = W_BEAT1;
            W_BEAT1: begin
                if (bus.bmem_write) wstate_d = W_BEAT2;
                else begin wstate_d = W_IDLE; proto_err_d = 1'b1; end
            end
            W_BEAT2: begin
                if (bus.bmem_write) wstate_d = W_BEAT3;
                else begin wstate_d = W_IDLE; proto_err_d = 1'b1; end
            end
            W_BEAT3: begin
                wstate_d = W_IDLE;
                if (bus.bmem_write) commit = 1'b1;
                else proto_err_d = 1'b1;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write FSM state, error flag and the "out of reset" qualifier for ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate_q    <= W_IDLE;
            proto_err_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            wstate_q    <= wstate_d;
            proto_err_q <= proto_err_d;
            live_q      <= 1'b1;
        end
    end

    // Burst staging and line array; the whole line lands in one edge so readers never see a partial line.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            widx_q        <= req_idx;
            wbuf_q[63:0]  <= bus.bmem_wdata;
        end
        if (wstate_q == W_BEAT1) wbuf_q[127:64]  <= bus.bmem_wdata;
        if (wstate_q == W_BEAT2) wbuf_q[191:128] <= bus.bmem_wdata;
        if (commit) mem_q[widx_q] <= {bus.bmem_wdata, wbuf_q};
    end

    // Read queue payload: line address, line snapshot and accept timestamp.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            qaddr_q[wptr_q] <= {bus.bmem_addr[31:5], 5'b0};
            qline_q[wptr_q] <= mem_q[req_idx];
            qts_q[wptr_q]   <= now_q;
        end
    end

    // Queue occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (rd_acc && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !rd_acc) cnt_d = cnt_q - 1'b1;
    end

    // Queue pointers, occupancy and free-running timestamp.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            now_q  <= '0;
        end else begin
            now_q <= now_q + 16'd1;
            if (rd_acc) wptr_q <= nxt_ptr(wptr_q);
            if (pop)    rptr_q <= nxt_ptr(rptr_q);
            cnt_q <= cnt_d;
        end
    end

    // Return engine: popping on the last beat of a burst chains bursts without a bubble.
    always_comb begin
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        raddr_d  = raddr_q;
        beat_d   = beat_q;
        line_d   = line_q;
        if (pop) begin
            rvalid_d = 1'b1;
            rdata_d  = qline_q[rptr_q][63:0];
            raddr_d  = qaddr_q[rptr_q];
            beat_d   = 2'd0;
            line_d   = qline_q[rptr_q];
        end else if (rvalid_q && beat_q != 2'd3) begin
            rvalid_d = 1'b1;
            beat_d   = beat_nxt;
            rdata_d  = line_q[{beat_nxt, 6'b0} +: 64];
        end
    end

    // Registered return outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            raddr_q  <= '0;
            beat_q   <= '0;
            line_q   <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            raddr_q  <= raddr_d;
            beat_q   <= beat_d;
            line_q   <= line_d;
        end
    end

    assign bus.bmem_ready  = ready;
    assign bus.bmem_raddr  = raddr_q;
    assign bus.bmem_rdata  = rdata_q;
    assign bus.bmem_rvalid = rvalid_q;
    assign bus.proto_err   = proto_err_q;
endmodule
